// File: rtl/tx_sched_arb.sv
// tx_sched_arb: round-robin scheduler sharing one serial transmitter
// among N_REQ requesters; latches the byte, starts tx, reports done/err.
module tx_sched_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int START_TO   = 20000,
  parameter int TO_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        err,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_pi,
  input  logic                        tx_busy,
  output logic                        sched_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW:0] NREQ_W = (IW+1)'(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic                  busy_m, busy_s;
  logic [IW-1:0]         last_q, last_d;
  logic [IW-1:0]         win_q, win_d;
  logic [IW-1:0]         pick;
  logic [IW:0]           cand;
  logic                  found;
  logic [DATA_WIDTH-1:0] tx_pi_q, tx_pi_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  to_q, to_d;
  logic [N_REQ-1:0]      win_oh;

  // tx_busy comes from the divided tx clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_m <= 1'b0;
      busy_s <= 1'b0;
    end else begin
      busy_m <= tx_busy;
      busy_s <= busy_m;
    end
  end

  // Scan from last+N down to last+1 so the nearest requester wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    tx_pi_d = tx_pi_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && found) begin
          win_d = pick;
          to_d  = 1'b0;
          for (int k = 0; k < N_REQ; k++) begin
            if (pick == IW'(k))
              tx_pi_d = req_data[k*DATA_WIDTH +: DATA_WIDTH];
          end
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = TO_WIDTH'(START_TO);
        state_d = S_START;
      end
      S_START: begin
        if (busy_s) begin
          state_d = S_WAIT;
        end else if (cnt_q <= TO_WIDTH'(1)) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - TO_WIDTH'(1);
        end
      end
      S_WAIT: begin
        if (!busy_s) state_d = S_ACK;
      end
      S_ACK: begin
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ-1);
      win_q   <= '0;
      tx_pi_q <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      tx_pi_q <= tx_pi_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign win_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << win_q;
  assign grant      = (state_q != S_IDLE) ? win_oh : '0;
  assign done       = (state_q == S_ACK) ? win_oh : '0;
  assign err        = (state_q == S_ACK) && to_q;
  assign tx_start   = (state_q == S_START);
  assign sched_busy = (state_q != S_IDLE);
  assign tx_pi      = tx_pi_q;

endmodule

// File: tb/tb_tx_sched_arb.sv
// tb_tx_sched_arb: directed scenarios for tx_sched_arb
// with a behavioural tx that answers tx_start with a busy frame.
module tb_tx_sched_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        tx_start;
  logic [7:0]  tx_pi;
  logic        tx_busy;
  logic        sched_busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit tx_mute  = 1'b0;

  always #5 clk = ~clk;

  tx_sched_arb #(
    .N_REQ(4),
    .DATA_WIDTH(8),
    .START_TO(10),
    .TO_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .done(done),
    .err(err),
    .tx_start(tx_start),
    .tx_pi(tx_pi),
    .tx_busy(tx_busy),
    .sched_busy(sched_busy)
  );

  // tx model: busy 3 clk after start, for 50 clk
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !tx_mute) begin
        repeat (3) @(negedge clk);
        tx_busy = 1'b1;
        repeat (50) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (grant != 4'b0000) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (done != 4'b0000) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_busy(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (tx_busy === lvl) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({grant, done, err, tx_start, tx_pi, sched_busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got g=%b d=%b e=%b s=%b pi=%h b=%b, want all 0",
               grant, done, err, tx_start, tx_pi, sched_busy);
    end
  endtask

  task automatic test_single();
    bit ok;
    req = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (grant !== 4'b0001 || tx_pi !== 8'h77 || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL single_load: got g=%b pi=%h s=%b, want 0001 77 0",
               grant, tx_pi, tx_start);
    end
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1) begin
      n_fail++;
      $display("FAIL single_start_lat: tx_start=%b, want 1", tx_start);
    end
    req = 4'b0000;
    wait_done(ok);
    n_checks++;
    if (!ok || done !== 4'b0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: ok=%b done=%b err=%b, want 1 0001 0",
               ok, done, err);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 4'b0000 || sched_busy !== 1'b0 || tx_pi !== 8'h77) begin
      n_fail++;
      $display("FAIL single_idle: done=%b busy=%b pi=%h, want 0000 0 77",
               done, sched_busy, tx_pi);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] exp_d [4];
    logic [3:0] oh;
    exp_d = '{8'h77, 8'hAA, 8'hA9, 8'h10};
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      wait_grant(ok);
      n_checks++;
      if (!ok || grant !== oh || tx_pi !== exp_d[k % 4]) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: g=%b pi=%h, want %b %h",
                 k, grant, tx_pi, oh, exp_d[k % 4]);
      end
      wait_done(ok);
      n_checks++;
      if (!ok || done !== oh) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: done=%b, want %b", k, done, oh);
      end
      if (k == 4) req = 4'b0000;
      @(negedge clk);
    end
    n_checks++;
    if (grant !== 4'b0000 || done !== 4'b0000) begin
      n_fail++;
      $display("FAIL rr_end: g=%b d=%b, want 0000 0000", grant, done);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    req = 4'b0100;
    wait_grant(ok);
    wait_done(ok);
    n_checks++;
    if (!ok || done !== 4'b0100) begin
      n_fail++;
      $display("FAIL wrap_first: done=%b, want 0100", done);
    end
    req = 4'b0101;
    @(negedge clk);
    wait_grant(ok);
    n_checks++;
    if (!ok || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_to0: grant=%b, want 0001", grant);
    end
    wait_done(ok);
    @(negedge clk);
    wait_grant(ok);
    n_checks++;
    if (!ok || grant !== 4'b0100 || tx_pi !== 8'hA9) begin
      n_fail++;
      $display("FAIL wrap_to2: grant=%b pi=%h, want 0100 A9", grant, tx_pi);
    end
    req = 4'b0000;
    wait_done(ok);
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int starts;
    tx_mute = 1'b1;
    req = 4'b1000;
    wait_grant(ok);
    n_checks++;
    if (!ok || grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL to_grant: grant=%b, want 1000", grant);
    end
    req = 4'b0000;
    starts = 0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (done != 4'b0000) ok = 1'b1;
      else if (tx_start) starts++;
    end
    n_checks++;
    if (!ok || starts != 10 || done !== 4'b1000 || err !== 1'b1
        || tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL to_ack: starts=%0d done=%b err=%b s=%b, want 10 1000 1 0",
               starts, done, err, tx_start);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || sched_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: err=%b busy=%b, want 0 0", err, sched_busy);
    end
    tx_mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    req = 4'b0100;
    wait_grant(ok);
    req = 4'b0000;
    wait_busy(1'b1, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (!ok || grant !== 4'b0100 || tx_start !== 1'b0 || sched_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: g=%b s=%b b=%b, want 0100 0 1",
               grant, tx_start, sched_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant, done, err, tx_start, tx_pi, sched_busy} !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_async: g=%b d=%b e=%b s=%b pi=%h b=%b, want all 0",
               grant, done, err, tx_start, tx_pi, sched_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy(1'b0, ok);
    repeat (4) @(negedge clk);
    req = 4'b0101;
    wait_grant(ok);
    n_checks++;
    if (!ok || grant !== 4'b0001 || tx_pi !== 8'h77) begin
      n_fail++;
      $display("FAIL rst_prio: grant=%b pi=%h, want 0001 77", grant, tx_pi);
    end
    req = 4'b0000;
    wait_done(ok);
    @(negedge clk);
  endtask

  task automatic test_enable();
    bit ok;
    int bad;
    en = 1'b0;
    req = 4'b0010;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (grant != 4'b0000 || sched_busy) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_block: %0d granted cycles, want 0", bad);
    end
    en = 1'b1;
    wait_grant(ok);
    n_checks++;
    if (!ok || grant !== 4'b0010 || tx_pi !== 8'hAA) begin
      n_fail++;
      $display("FAIL en_grant: grant=%b pi=%h, want 0010 AA", grant, tx_pi);
    end
    wait_busy(1'b1, ok);
    repeat (5) @(negedge clk);
    en = 1'b0;
    wait_done(ok);
    n_checks++;
    if (!ok || done !== 4'b0010 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL en_mid_done: done=%b err=%b, want 0010 0", done, err);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant != 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL en_no_regrant: %0d granted cycles, want 0", bad);
    end
    en = 1'b1;
    wait_grant(ok);
    req = 4'b0000;
    wait_done(ok);
    n_checks++;
    if (!ok || done !== 4'b0010) begin
      n_fail++;
      $display("FAIL en_resume: done=%b, want 0010", done);
    end
    @(negedge clk);
  endtask

  initial begin
    req_data = {8'h10, 8'hA9, 8'hAA, 8'h77};
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
